ddr4_cmd_driver: RTL and testbench

//  Abstract-command to DDR4 CA-bus driver for the simulation stimulus; sits directly upstream of the x8 DDR4 model wrapper.

---
 rtl/ddr4_cmd_pkg.sv | 68 ++++++
 rtl/ddr4_gap_timer.sv | 26 ++
 rtl/ddr4_cmd_driver.sv | 174 +++++++++++++++++
 tb/tb_ddr4_cmd_driver.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_cmd_pkg.sv
// Shared types, timing constants and pin encodings for the DDR4 CA-bus command driver.
package ddr4_cmd_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ACT  = 4'd1,
    OP_RD   = 4'd2,
    OP_WR   = 4'd3,
    OP_PRE  = 4'd4,
    OP_PREA = 4'd5,
    OP_REF  = 4'd6,
    OP_MRS  = 4'd7,
    OP_ZQCL = 4'd8
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_CKE_WAIT = 2'd1,
    ST_IDLE     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam logic [15:0] RESET_CYC = 16'd200;
  localparam logic [15:0] CKE_CYC   = 16'd500;
  localparam logic [15:0] T_RCD     = 16'd11;
  localparam logic [15:0] T_RP      = 16'd11;
  localparam logic [15:0] T_CCD     = 16'd4;
  localparam logic [15:0] T_RFC     = 16'd128;
  localparam logic [15:0] T_MOD     = 16'd24;
  localparam logic [15:0] T_ZQ      = 16'd512;

  // {act_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CTL_DES  = 4'b1111;
  localparam logic [3:0] CTL_NOP  = 4'b1111;
  localparam logic [3:0] CTL_RD   = 4'b1101;
  localparam logic [3:0] CTL_WR   = 4'b1100;
  localparam logic [3:0] CTL_PRE  = 4'b1010;
  localparam logic [3:0] CTL_REF  = 4'b1001;
  localparam logic [3:0] CTL_MRS  = 4'b1000;
  localparam logic [3:0] CTL_ZQCL = 4'b1110;

  function automatic logic [15:0] gap_of(cmd_op_t op);
    case (op)
      OP_ACT:          return T_RCD;
      OP_RD, OP_WR:    return T_CCD;
      OP_PRE, OP_PREA: return T_RP;
      OP_REF:          return T_RFC;
      OP_MRS:          return T_MOD;
      OP_ZQCL:         return T_ZQ;
      default:         return 16'd1;
    endcase
  endfunction

  // ACT reuses ras/cas/we as row address bits A16:A14.
  function automatic logic [3:0] ctl_of(cmd_op_t op, logic [2:0] row_hi);
    case (op)
      OP_ACT:          return {1'b0, row_hi};
      OP_RD:           return CTL_RD;
      OP_WR:           return CTL_WR;
      OP_PRE, OP_PREA: return CTL_PRE;
      OP_REF:          return CTL_REF;
      OP_MRS:          return CTL_MRS;
      OP_ZQCL:         return CTL_ZQCL;
      default:         return CTL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ddr4_gap_timer.sv
// 16-bit load/down-counter with zero flag; holds at zero until reloaded.
module ddr4_gap_timer #(
  parameter logic [15:0] RST_VAL = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == 16'd0);

endmodule

// File: rtl/ddr4_cmd_driver.sv
// Abstract command to DDR4 CA-bus driver with power-up sequencing and per-command gap enforcement.
// Optional CA parity and ALERT_n counting are built when DDR4_CA_PARITY_EN is defined.
//
// state       | meaning
// ST_RST_HOLD | mem_reset_n held low, timer counting RESET_CYC
// ST_CKE_WAIT | mem_reset_n high, mem_cke low, timer counting CKE_CYC
// ST_IDLE     | ready for a command
// ST_GAP      | spacing after a command; ready again once the timer is zero
module ddr4_cmd_driver
  import ddr4_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [1:0]  cmd_bg,
  input  logic [1:0]  cmd_ba,
  input  logic [17:0] cmd_addr,
  output logic        init_done,
  output logic        mem_reset_n,
  output logic        mem_cke,
  output logic        mem_cs_n,
  output logic        mem_act_n,
  output logic        mem_ras_n,
  output logic        mem_cas_n,
  output logic        mem_we_n,
  output logic [1:0]  mem_bg,
  output logic [1:0]  mem_ba,
  output logic [13:0] mem_sa,
  output logic        mem_sa17,
  output logic        mem_par,
  input  logic        mem_alert_n,
  output logic [7:0]  alert_cnt
);

  state_t      state_q, state_d;
  cmd_op_t     op;
  logic [15:0] op_gap;
  logic        accept;
  logic        tmr_load, tmr_zero;
  logic [15:0] tmr_val;

  logic        rst_pin_d, cke_d, cs_d, sa17_d, par_d;
  logic [3:0]  ctl_d;
  logic [1:0]  bg_d, ba_d;
  logic [13:0] sa_d;

  assign op        = cmd_op_t'(cmd_op);
  assign op_gap    = gap_of(op);
  assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_GAP) && tmr_zero);
  assign accept    = cmd_valid && cmd_ready;

  ddr4_gap_timer #(.RST_VAL(RESET_CYC - 16'd1)) u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RST_HOLD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = 16'd0;
    case (state_q)
      ST_RST_HOLD: begin
        if (tmr_zero) begin
          state_d  = ST_CKE_WAIT;
          tmr_load = 1'b1;
          tmr_val  = CKE_CYC - 16'd1;
        end
      end
      ST_CKE_WAIT: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      default: begin
        if (accept) begin
          if (op_gap > 16'd1) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = op_gap - 16'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((state_q == ST_GAP) && tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    rst_pin_d = (state_d != ST_RST_HOLD);
    cke_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
    cs_d      = 1'b1;
    ctl_d     = CTL_DES;
    bg_d      = 2'd0;
    ba_d      = 2'd0;
    sa_d      = 14'd0;
    sa17_d    = 1'b0;
    if (accept) begin
      cs_d   = 1'b0;
      ctl_d  = ctl_of(op, cmd_addr[16:14]);
      bg_d   = cmd_bg;
      ba_d   = cmd_ba;
      sa_d   = cmd_addr[13:0];
      sa17_d = cmd_addr[17];
      // A10 selects single-bank vs all-bank precharge and long ZQ calibration.
      if (op == OP_PRE)                        sa_d[10] = 1'b0;
      else if (op == OP_PREA || op == OP_ZQCL) sa_d[10] = 1'b1;
    end
`ifdef DDR4_CA_PARITY_EN
    par_d = accept ? ^{ctl_d, bg_d, ba_d, sa17_d, sa_d} : 1'b0;
`else
    par_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_reset_n <= 1'b0;
      mem_cke     <= 1'b0;
      init_done   <= 1'b0;
      mem_cs_n    <= 1'b1;
      {mem_act_n, mem_ras_n, mem_cas_n, mem_we_n} <= CTL_DES;
      mem_bg      <= 2'd0;
      mem_ba      <= 2'd0;
      mem_sa      <= 14'd0;
      mem_sa17    <= 1'b0;
      mem_par     <= 1'b0;
    end else begin
      mem_reset_n <= rst_pin_d;
      mem_cke     <= cke_d;
      init_done   <= cke_d;
      mem_cs_n    <= cs_d;
      {mem_act_n, mem_ras_n, mem_cas_n, mem_we_n} <= ctl_d;
      mem_bg      <= bg_d;
      mem_ba      <= ba_d;
      mem_sa      <= sa_d;
      mem_sa17    <= sa17_d;
      mem_par     <= par_d;
    end
  end

`ifdef DDR4_CA_PARITY_EN
  // [1:0] synchroniser, [2] previous synchronised value for fall detection.
  logic [2:0] alert_sync;
  logic [7:0] alert_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alert_sync  <= 3'b111;
      alert_cnt_q <= 8'd0;
    end else begin
      alert_sync <= {alert_sync[1:0], mem_alert_n};
      if (alert_sync[2] && !alert_sync[1] && (alert_cnt_q != 8'hFF))
        alert_cnt_q <= alert_cnt_q + 8'd1;
    end
  end

  assign alert_cnt = alert_cnt_q;
`else
  logic alert_unused;
  assign alert_unused = mem_alert_n;
  assign alert_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_ddr4_cmd_driver.sv
// Randomised self-checking bench for ddr4_cmd_driver against a timing/encoding reference model.
module tb_ddr4_cmd_driver;

`ifdef DDR4_CA_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam int LIMIT = 2000;
  localparam logic [36:0] RST_VEC = {2'b00, 1'b1, 4'b1111, 30'b0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [1:0]  cmd_bg = 2'd0;
  logic [1:0]  cmd_ba = 2'd0;
  logic [17:0] cmd_addr = 18'd0;
  logic        init_done, mem_reset_n, mem_cke, mem_cs_n;
  logic        mem_act_n, mem_ras_n, mem_cas_n, mem_we_n;
  logic [1:0]  mem_bg, mem_ba;
  logic [13:0] mem_sa;
  logic        mem_sa17, mem_par;
  logic        mem_alert_n = 1'b1;
  logic [7:0]  alert_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_low_cnt = 0;
  int sent_cnt = 0;
  int last_pin_cyc = 0;
  logic [3:0] last_op = 4'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_cs_n === 1'b0) cs_low_cnt++;

  ddr4_cmd_driver dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .init_done(init_done), .mem_reset_n(mem_reset_n), .mem_cke(mem_cke),
    .mem_cs_n(mem_cs_n), .mem_act_n(mem_act_n), .mem_ras_n(mem_ras_n),
    .mem_cas_n(mem_cas_n), .mem_we_n(mem_we_n), .mem_bg(mem_bg), .mem_ba(mem_ba),
    .mem_sa(mem_sa), .mem_sa17(mem_sa17), .mem_par(mem_par),
    .mem_alert_n(mem_alert_n), .alert_cnt(alert_cnt)
  );

  logic [36:0] out_vec;
  logic [24:0] pin_vec;
  logic [3:0]  ctl;
  assign ctl     = {mem_act_n, mem_ras_n, mem_cas_n, mem_we_n};
  assign out_vec = {mem_reset_n, mem_cke, mem_cs_n, ctl, mem_bg, mem_ba, mem_sa,
                    mem_sa17, mem_par, cmd_ready, init_done, alert_cnt};
  assign pin_vec = {mem_cs_n, ctl, mem_bg, mem_ba, mem_sa, mem_sa17, mem_par};

  function automatic int gap_tb(logic [3:0] op);
    case (op)
      4'd1:       return 11;
      4'd2, 4'd3: return 4;
      4'd4, 4'd5: return 11;
      4'd6:       return 128;
      4'd7:       return 24;
      4'd8:       return 512;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [3:0] exp_ctl(logic [3:0] op, logic [17:0] a);
    case (op)
      4'd1:       return {1'b0, a[16:14]};
      4'd2:       return 4'b1101;
      4'd3:       return 4'b1100;
      4'd4, 4'd5: return 4'b1010;
      4'd6:       return 4'b1001;
      4'd7:       return 4'b1000;
      4'd8:       return 4'b1110;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [24:0] exp_pins(logic [3:0] op, logic [1:0] bg, logic [1:0] ba,
                                           logic [17:0] a);
    logic [13:0] s;
    logic [3:0]  c;
    logic        p;
    s = a[13:0];
    if (op == 4'd4) s[10] = 1'b0;
    else if (op == 4'd5 || op == 4'd8) s[10] = 1'b1;
    c = exp_ctl(op, a);
    p = PAR_EN & (^{c, bg, ba, a[17], s});
    return {1'b0, c, bg, ba, s, a[17], p};
  endfunction

  // Present a command from a negedge, wait for ready, return at the negedge where it is on the pins.
  task automatic send(input logic [3:0] op, input logic [1:0] bg, input logic [1:0] ba,
                      input logic [17:0] addr, output int req_cyc, output int waited,
                      output bit ok);
    cmd_op = op; cmd_bg = bg; cmd_ba = ba; cmd_addr = addr; cmd_valid = 1'b1;
    req_cyc = cyc;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    ok = (cmd_ready === 1'b1);
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      last_op = op;
      last_pin_cyc = cyc;
      sent_cnt++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic run_init();
    int n;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (mem_reset_n !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 200) begin errors++; $display("FAIL init_reset_len: got %0d cycles, expected 200", n); end
    checks++;
    if ({mem_cke, init_done, cmd_ready} !== 3'b000) begin
      errors++; $display("FAIL init_cke_early: got %b, expected 000", {mem_cke, init_done, cmd_ready});
    end
    n = 0;
    while (mem_cke !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 500) begin errors++; $display("FAIL init_cke_len: got %0d cycles, expected 500", n); end
    checks++;
    if ({init_done, cmd_ready} !== 2'b11) begin
      errors++; $display("FAIL init_done_ready: got %b, expected 11", {init_done, cmd_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_values: got %h, expected %h", out_vec, RST_VEC);
    end
    run_init();
  endtask

  task automatic test_act();
    int rq, w; bit ok;
    logic [24:0] e;
    send(4'd1, 2'd1, 2'd2, 18'h25A5A, rq, w, ok);
    e = {1'b0, 4'b0001, 2'd1, 2'd2, 14'h1A5A, 1'b1, PAR_EN};
    checks++;
    if (!ok || pin_vec !== e) begin
      errors++; $display("FAIL act_pins: got %h, expected %h (accepted=%0d)", pin_vec, e, ok);
    end
    @(negedge clk);
    checks++;
    if ({mem_cs_n, ctl} !== 5'b11111) begin
      errors++; $display("FAIL act_des: got %b, expected 11111", {mem_cs_n, ctl});
    end
  endtask

  task automatic test_back_to_back();
    int rq, w, t0; bit ok;
    logic [17:0] a;
    a = 18'($urandom());
    send(4'd2, 2'd0, 2'd3, a, rq, w, ok);
    t0 = last_pin_cyc;
    checks++;
    if (!ok || {mem_cs_n, ctl, cmd_ready} !== 6'b011010) begin
      errors++; $display("FAIL rd1_pins: got %b, expected 011010", {mem_cs_n, ctl, cmd_ready});
    end
    @(negedge clk);
    checks++;
    if ({mem_cs_n, ctl, cmd_ready} !== 6'b111110) begin
      errors++; $display("FAIL rd1_des: got %b, expected 111110", {mem_cs_n, ctl, cmd_ready});
    end
    send(4'd2, 2'd2, 2'd1, a ^ 18'h3FFFF, rq, w, ok);
    checks++;
    if (!ok || last_pin_cyc - t0 != 4) begin
      errors++; $display("FAIL rd_spacing: got %0d, expected 4", last_pin_cyc - t0);
    end
    checks++;
    if (1 + w != 3) begin errors++; $display("FAIL rd_ready_low: got %0d cycles, expected 3", 1 + w); end
    checks++;
    if ({mem_cs_n, ctl} !== 5'b01101) begin
      errors++; $display("FAIL rd2_pins: got %b, expected 01101", {mem_cs_n, ctl});
    end
  endtask

  task automatic test_ref_pre_zq();
    int rq, w, t0; bit ok;
    send(4'd6, 2'd0, 2'd0, 18'd0, rq, w, ok);
    t0 = last_pin_cyc;
    checks++;
    if (!ok || {mem_cs_n, ctl} !== 5'b01001) begin
      errors++; $display("FAIL ref_pins: got %b, expected 01001", {mem_cs_n, ctl});
    end
    send(4'd2, 2'd1, 2'd1, 18'h00123, rq, w, ok);
    checks++;
    if (!ok || last_pin_cyc - t0 != 128) begin
      errors++; $display("FAIL ref_rd_spacing: got %0d, expected 128", last_pin_cyc - t0);
    end
    send(4'd4, 2'd3, 2'd2, 18'h00400, rq, w, ok);
    checks++;
    if (!ok || {ctl, mem_sa[10]} !== 5'b10100) begin
      errors++; $display("FAIL pre_a10: got %b, expected 10100", {ctl, mem_sa[10]});
    end
    send(4'd5, 2'd0, 2'd0, 18'h3FBFF, rq, w, ok);
    t0 = last_pin_cyc;
    checks++;
    if (!ok || {ctl, mem_sa[10]} !== 5'b10101) begin
      errors++; $display("FAIL prea_a10: got %b, expected 10101", {ctl, mem_sa[10]});
    end
    send(4'd8, 2'd0, 2'd0, 18'h00000, rq, w, ok);
    checks++;
    if (!ok || {ctl, mem_sa[10]} !== 5'b11101 || last_pin_cyc - t0 != 11) begin
      errors++; $display("FAIL zqcl_a10: got %b spacing %0d, expected 11101 spacing 11",
                         {ctl, mem_sa[10]}, last_pin_cyc - t0);
    end
  endtask

  task automatic test_random();
    int rq, w, d, p_cyc, exp_cyc; bit ok;
    logic [3:0] op, p_op;
    logic [1:0] bg, ba;
    logic [17:0] a;
    logic [24:0] e;
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      repeat (d) @(negedge clk);
      op = 4'($urandom_range(0, 15));
      bg = 2'($urandom_range(0, 3));
      ba = 2'($urandom_range(0, 3));
      a  = 18'($urandom());
      p_cyc = last_pin_cyc;
      p_op  = last_op;
      send(op, bg, ba, a, rq, w, ok);
      exp_cyc = (p_cyc + gap_tb(p_op) > rq + 1) ? p_cyc + gap_tb(p_op) : rq + 1;
      checks++;
      if (!ok || last_pin_cyc != exp_cyc) begin
        errors++; $display("FAIL rand_timing[%0d] op=%0d: got cycle %0d, expected %0d",
                           i, op, last_pin_cyc, exp_cyc);
      end
      e = exp_pins(op, bg, ba, a);
      checks++;
      if (pin_vec !== e) begin
        errors++; $display("FAIL rand_pins[%0d] op=%0d: got %h, expected %h", i, op, pin_vec, e);
      end
    end
    @(negedge clk);
    checks++;
    if (cs_low_cnt != sent_cnt) begin
      errors++; $display("FAIL cs_count: got %0d cs_n low cycles, expected %0d", cs_low_cnt, sent_cnt);
    end
  endtask

  task automatic test_midgap_reset();
    int rq, w; bit ok;
    send(4'd6, 2'd1, 2'd1, 18'h0ABCD, rq, w, ok);
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++; $display("FAIL midgap_reset: got %h, expected %h", out_vec, RST_VEC);
    end
    run_init();
  endtask

  task automatic test_invalid_alert();
    int rq, w, t0; bit ok;
    send(4'hF, 2'd2, 2'd1, 18'h15555, rq, w, ok);
    t0 = last_pin_cyc;
    checks++;
    if (!ok || pin_vec !== exp_pins(4'hF, 2'd2, 2'd1, 18'h15555) || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL invalid_nop: got %h ready %b, expected %h ready 1",
                         pin_vec, cmd_ready, exp_pins(4'hF, 2'd2, 2'd1, 18'h15555));
    end
    send(4'd9, 2'd0, 2'd0, 18'h00001, rq, w, ok);
    checks++;
    if (!ok || last_pin_cyc - t0 != 1) begin
      errors++; $display("FAIL invalid_spacing: got %0d, expected 1", last_pin_cyc - t0);
    end
    mem_alert_n = 1'b0;
    repeat (3) @(negedge clk);
    mem_alert_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (alert_cnt !== {7'd0, PAR_EN}) begin
      errors++; $display("FAIL alert_single: got %0d, expected %0d", alert_cnt, PAR_EN);
    end
    repeat (300) begin
      mem_alert_n = 1'b0;
      repeat (2) @(negedge clk);
      mem_alert_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (alert_cnt !== (PAR_EN ? 8'hFF : 8'h00)) begin
      errors++; $display("FAIL alert_saturate: got %h, expected %h", alert_cnt, PAR_EN ? 8'hFF : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_act();
    test_back_to_back();
    test_ref_pre_zq();
    test_random();
    test_midgap_reset();
    test_invalid_alert();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
